// File: rtl/wbuwritecw.sv
// Codeword-to-hexbit serializer: emits a 36-bit codeword as 6-bit chars,
// MSB first, and inserts a newline marker after an idle gap.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_stb, i_codword codeword in; accepted only while o_busy==0
//   o_busy           cannot accept a codeword this cycle
//   o_stb, o_valid   char strobe; o_valid=0 marks a newline
//   o_hexbits        char payload
//   i_tx_busy        downstream stall
module wbuwritecw #(
  parameter int IDLE_NL = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb,
  input  logic [35:0] i_codword,
  output logic        o_busy,
  output logic        o_stb,
  output logic        o_valid,
  output logic [5:0]  o_hexbits,
  input  logic        i_tx_busy
);

  localparam int CW = (IDLE_NL < 2) ? 1 : $clog2(IDLE_NL + 1);
  localparam logic [CW-1:0] NL_END = CW'(IDLE_NL);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    NEWLINE
  } state_t;

  state_t         state;
  logic [35:0]    sh;
  logic [2:0]     rem;
  logic           nl_pend;
  logic [CW-1:0]  idle_cnt;

  // Char count from the five header bits.
  function automatic logic [2:0] cw_len(input logic [4:0] h);
    logic [2:0] n;
    n = 3'd6;
    unique case (1'b1)
      (h[4:3] == 2'b11):  n = 3'd2;
      (h[4:3] == 2'b10):  n = 3'd1;
      (h[4:2] == 3'b010): n = 3'd2;
      (h[4:2] == 3'b001): n = 3'd2 + {1'b0, h[1:0]};
      default:            n = 3'd6;
    endcase
    return n;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      sh        <= '0;
      rem       <= '0;
      nl_pend   <= 1'b0;
      idle_cnt  <= '0;
      o_busy    <= 1'b0;
      o_stb     <= 1'b0;
      o_valid   <= 1'b0;
      o_hexbits <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_stb) begin
            state     <= SEND;
            o_busy    <= 1'b1;
            o_stb     <= 1'b1;
            o_valid   <= 1'b1;
            o_hexbits <= i_codword[35:30];
            // sh holds the not-yet-presented chars, left aligned
            sh        <= {i_codword[29:0], 6'h0};
            rem       <= cw_len(i_codword[35:31]) - 3'd1;
            idle_cnt  <= '0;
          end else if (nl_pend) begin
            if (idle_cnt != NL_END)
              idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == NL_END - 1'b1) begin
              state     <= NEWLINE;
              o_busy    <= 1'b1;
              o_stb     <= 1'b1;
              o_valid   <= 1'b0;
              o_hexbits <= '0;
            end
          end
        end
        SEND: begin
          if (!i_tx_busy) begin
            if (rem != 3'd0) begin
              rem       <= rem - 3'd1;
              o_hexbits <= sh[35:30];
              sh        <= {sh[29:0], 6'h0};
            end else begin
              state   <= IDLE;
              o_busy  <= 1'b0;
              o_stb   <= 1'b0;
              o_valid <= 1'b0;
              if (IDLE_NL != 0) begin
                nl_pend  <= 1'b1;
                idle_cnt <= '0;
              end
            end
          end
        end
        NEWLINE: begin
          if (!i_tx_busy) begin
            state   <= IDLE;
            o_busy  <= 1'b0;
            o_stb   <= 1'b0;
            nl_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbuwritecw.sv
// Directed bench for wbuwritecw (IDLE_NL=4): table of codewords with
// hand-decoded chars, plus stall, newline, busy and reset sequences.
module tb_wbuwritecw;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stb = 1'b0;
  logic [35:0] cw  = '0;
  logic        busy, ostb, valid, txb;
  logic [5:0]  hex;

  initial txb = 1'b0;

  wbuwritecw #(.IDLE_NL(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_stb     (stb),
    .i_codword (cw),
    .o_busy    (busy),
    .o_stb     (ostb),
    .o_valid   (valid),
    .o_hexbits (hex),
    .i_tx_busy (txb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [5:0] d;
    int         t;
  } ch_t;

  typedef struct {
    logic [35:0]      cw;
    int               n;
    logic [0:5][5:0]  c;
  } vec_t;

  ch_t  q[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nbad = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (ostb && !txb && !rst)
      q.push_back('{valid, hex, cyc});

  task automatic chk(input string nm, input logic [35:0] act,
                     input logic [35:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic send(input logic [35:0] w);
    stb = 1'b1;
    cw  = w;
    tick(1);
    stb = 1'b0;
    cw  = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick(1);
    end
    chk("idle_tmo", 36'(n < 50), 36'd1);
  endtask

  vec_t vt[10];
  int   n;
  int   lt;

  initial begin
    vt[0] = '{{6'h23, 30'h0}, 1, {6'h23, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0}};
    vt[1] = '{36'h012345678, 6,
              {6'h00, 6'h12, 6'h0D, 6'h05, 6'h19, 6'h38}};
    vt[2] = '{{6'h0E, 30'h3FFFFFFF}, 5,
              {6'h0E, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h0}};
    vt[3] = '{{6'h30, 30'h2AAAAAAA}, 2,
              {6'h30, 6'h2A, 6'h0, 6'h0, 6'h0, 6'h0}};
    vt[4] = '{{6'h14, 6'h21, 24'h0}, 2,
              {6'h14, 6'h21, 6'h0, 6'h0, 6'h0, 6'h0}};
    vt[5] = '{{6'h08, 6'h11, 6'h22, 18'h3FFFF}, 2,
              {6'h08, 6'h11, 6'h0, 6'h0, 6'h0, 6'h0}};
    vt[6] = '{{6'h0A, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05}, 3,
              {6'h0A, 6'h01, 6'h02, 6'h0, 6'h0, 6'h0}};
    vt[7] = '{{6'h1F, 6'h3E, 6'h01, 6'h20, 6'h15, 6'h2A}, 6,
              {6'h1F, 6'h3E, 6'h01, 6'h20, 6'h15, 6'h2A}};
    vt[8] = '{{6'h2C, 6'h3F, 24'hFFFFFF}, 1,
              {6'h2C, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0}};
    vt[9] = '{{6'h3F, 6'h00, 24'hFFFFFF}, 2,
              {6'h3F, 6'h00, 6'h0, 6'h0, 6'h0, 6'h0}};

    tick(1);
    reset_dut();
    chk("rst_busy",  36'(busy),  36'd0);
    chk("rst_stb",   36'(ostb),  36'd0);
    chk("rst_valid", 36'(valid), 36'd0);
    chk("rst_hex",   36'(hex),   36'd0);
    tick(10);
    chk("rst_no_nl", 36'(q.size()), 36'd0);

    // table: chars, then exactly one newline 5 cycles after the last char
    for (int i = 0; i < 10; i++) begin
      reset_dut();
      send(vt[i].cw);
      wait_idle(n);
      tick(8);
      chk($sformatf("v%0d_cnt", i), 36'(q.size()), 36'(vt[i].n + 1));
      for (int k = 0; k < vt[i].n && k < q.size(); k++) begin
        chk($sformatf("v%0d_c%0d", i, k), {29'd0, q[k].v, q[k].d},
            {29'd0, 1'b1, vt[i].c[k]});
        if (k > 0)
          chk($sformatf("v%0d_gap%0d", i, k),
              36'(q[k].t - q[k-1].t), 36'd1);
      end
      if (q.size() == vt[i].n + 1) begin
        chk($sformatf("v%0d_nl", i), {29'd0, q[vt[i].n].v, q[vt[i].n].d},
            36'd0);
        chk($sformatf("v%0d_nlt", i),
            36'(q[vt[i].n].t - q[vt[i].n-1].t), 36'd5);
      end
    end

    // 1 char: busy exactly one cycle
    reset_dut();
    send({6'h23, 30'h0});
    wait_idle(n);
    chk("busy_1c", 36'(n), 36'd1);

    // 6 chars: next accept 7 cycles after the first
    reset_dut();
    send(36'h012345678);
    wait_idle(n);
    chk("accept_gap", 36'(n + 1), 36'd7);
    send({6'h23, 30'h0});
    chk("b2b_acc", 36'(busy), 36'd1);
    wait_idle(n);

    // stall on char 2
    reset_dut();
    send(36'h012345678);
    tick(2);
    txb = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick(1);
      chk($sformatf("stall_hex%0d", s), 36'(hex), 36'h0D);
      chk($sformatf("stall_stb%0d", s), 36'(ostb), 36'd1);
    end
    txb = 1'b0;
    wait_idle(n);
    chk("stall_cnt", 36'(q.size()), 36'd6);
    if (q.size() == 6)
      chk("stall_seq",
          {q[0].d, q[1].d, q[2].d, q[3].d, q[4].d, q[5].d},
          {6'h00, 6'h12, 6'h0D, 6'h05, 6'h19, 6'h38});

    // newline suppressed by a codeword at idle cycle 2, re-armed after
    reset_dut();
    send({6'h23, 30'h0});
    tick(3);
    send({6'h2C, 30'h0});
    tick(10);
    chk("sup_cnt", 36'(q.size()), 36'd3);
    if (q.size() == 3) begin
      chk("sup_c0", {q[0].v, q[0].d}, {1'b1, 6'h23});
      chk("sup_c1", {q[1].v, q[1].d}, {1'b1, 6'h2C});
      chk("sup_nl", {q[2].v, q[2].d}, 36'd0);
      chk("sup_nlt", 36'(q[2].t - q[1].t), 36'd5);
    end
    tick(20);
    chk("one_nl", 36'(q.size()), 36'd3);

    // i_stb while busy is ignored
    reset_dut();
    send(36'h012345678);
    stb = 1'b1;
    cw  = {6'h23, 30'h0};
    tick(3);
    stb = 1'b0;
    wait_idle(n);
    chk("ign_cnt", 36'(q.size()), 36'd6);
    if (q.size() == 6)
      chk("ign_last", 36'(q[5].d), 36'h38);
    tick(1);
    chk("ign_nobusy", 36'(busy), 36'd0);

    // reset during char 3
    reset_dut();
    send(36'h012345678);
    tick(3);
    chk("mid_hex", 36'(hex), 36'h05);
    rst = 1'b1;
    tick(1);
    chk("mid_stb", 36'(ostb), 36'd0);
    chk("mid_busy", 36'(busy), 36'd0);
    rst = 1'b0;
    tick(10);
    chk("mid_no_nl", 36'(q.size()), 36'd3);
    send({6'h23, 30'h0});
    wait_idle(n);
    chk("mid_new_cnt", 36'(q.size()), 36'd4);
    if (q.size() == 4)
      chk("mid_new_c", {q[3].v, q[3].d}, {1'b1, 6'h23});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
